// File: rtl/quote_update_sequencer_pkg.sv
// Shared widths, order-book command encodings and the sequencer state type.
package quote_update_sequencer_pkg;

   localparam int unsigned STOCK_INDEX     = 1;
   localparam int unsigned NUM_STOCK_INDEX = 3;
   localparam int unsigned PRICE_INDEX     = 15;
   localparam int unsigned ORDER_INDEX     = 7;
   localparam int unsigned QUANTITY_INDEX  = 7;

   localparam int unsigned STOCK_W    = STOCK_INDEX + 1;
   localparam int unsigned PRICE_W    = PRICE_INDEX + 1;
   localparam int unsigned ORDER_W    = ORDER_INDEX + 1;
   localparam int unsigned QUANTITY_W = QUANTITY_INDEX + 1;

   localparam logic [2:0] ADD_ORDER    = 3'd1;
   localparam logic [2:0] CANCEL_ORDER = 3'd2;

   typedef struct packed {
      logic [PRICE_INDEX:0]    price;
      logic [ORDER_INDEX:0]    order_id;
      logic [QUANTITY_INDEX:0] quantity;
   } book_entry_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE_CXL,
      S_WAIT_CXL,
      S_ISSUE_ADD,
      S_WAIT_ADD,
      S_FLUSH_SCAN
   } seq_state_t;

endpackage

// File: rtl/quote_update_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra wrap bit to tell full from empty.
module quote_update_fifo #(
   parameter int unsigned WIDTH = 18,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q;
   logic [AW:0]      rd_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty_o = (wr_q == rd_q);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + (AW+1)'(1);
         if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/quote_update_sequencer.sv
// Serialises buffered per-stock quote updates into cancel/add commands for the order book,
// tracking which stocks have a resting order and supporting a cancel-all flush.
module quote_update_sequencer
   import quote_update_sequencer_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ORDER_ID   = 1,
   parameter int unsigned QUANTITY   = 1
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     upd_valid,
   output logic                     upd_ready,
   input  logic [STOCK_INDEX:0]     upd_stock,
   input  logic [PRICE_INDEX:0]     upd_price,
   input  logic                     flush,
   output logic [STOCK_INDEX:0]     book_stock,
   output book_entry_t              book_entry,
   output logic                     book_start,
   output logic [2:0]               book_request,
   output logic [ORDER_INDEX:0]     book_order_id,
   output logic                     book_delete,
   output logic [QUANTITY_INDEX:0]  book_quantity,
   input  logic                     book_busy,
   output logic [NUM_STOCK_INDEX:0] live_mask,
   output logic                     idle,
   output logic [15:0]              upd_done_cnt
);

   localparam logic [ORDER_INDEX:0]    OID = ORDER_W'(ORDER_ID);
   localparam logic [QUANTITY_INDEX:0] QTY = QUANTITY_W'(QUANTITY);

   seq_state_t                 state_q, state_d;
   logic [STOCK_INDEX:0]       stock_q, stock_d, idx_q, idx_d;
   logic [PRICE_INDEX:0]       price_q, price_d;
   logic                       flushing_q, flushing_d, flush_pend_q, flush_pend_d;
   logic                       first_q, first_d;
   logic [NUM_STOCK_INDEX:0]   live_q, live_d;
   logic [15:0]                cnt_q, cnt_d;
   logic [STOCK_INDEX:0]       cmd_stock_q, cmd_stock_d;
   logic [2:0]                 cmd_req_q, cmd_req_d;
   logic [PRICE_INDEX:0]       cmd_price_q, cmd_price_d;
   logic [ORDER_INDEX:0]       oid_q, oid_d;
   logic [QUANTITY_INDEX:0]    qty_q, qty_d;

   logic                       fifo_full, fifo_empty, pop, exit_wait;
   logic [STOCK_INDEX:0]       head_stock;
   logic [PRICE_INDEX:0]       head_price;
   logic                       ld;
   logic [STOCK_INDEX:0]       ld_stock;
   logic [2:0]                 ld_req;
   logic [PRICE_INDEX:0]       ld_price;

   quote_update_fifo #(
      .WIDTH (STOCK_W + PRICE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_in),
      .rst_i   (rst_in),
      .push_i  (upd_valid && upd_ready),
      .wdata_i ({upd_stock, upd_price}),
      .pop_i   (pop),
      .rdata_o ({head_stock, head_price}),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign upd_ready     = !fifo_full;
   assign exit_wait     = !first_q && !book_busy;
   assign book_start    = (state_q == S_ISSUE_CXL) || (state_q == S_ISSUE_ADD);
   assign book_stock    = cmd_stock_q;
   assign book_request  = cmd_req_q;
   assign book_delete   = (cmd_req_q == CANCEL_ORDER);
   assign book_order_id = oid_q;
   assign book_quantity = qty_q;
   assign book_entry    = '{price: cmd_price_q, order_id: oid_q, quantity: qty_q};
   assign live_mask     = live_q;
   assign upd_done_cnt  = cnt_q;
   assign idle          = (state_q == S_IDLE) && fifo_empty && !flush_pend_q;

   always_comb begin
      state_d      = state_q;
      stock_d      = stock_q;
      price_d      = price_q;
      idx_d        = idx_q;
      flushing_d   = flushing_q;
      flush_pend_d = flush_pend_q | flush;
      first_d      = 1'b0;
      live_d       = live_q;
      cnt_d        = cnt_q;
      pop          = 1'b0;
      ld           = 1'b0;
      ld_stock     = stock_q;
      ld_req       = ADD_ORDER;
      ld_price     = price_q;
      case (state_q)
         S_IDLE: begin
            if (flush_pend_q) begin
               state_d    = S_FLUSH_SCAN;
               idx_d      = '0;
               flushing_d = 1'b1;
            end else if (!fifo_empty) begin
               pop      = 1'b1;
               stock_d  = head_stock;
               price_d  = head_price;
               ld       = 1'b1;
               ld_stock = head_stock;
               ld_price = head_price;
               ld_req   = live_q[head_stock] ? CANCEL_ORDER : ADD_ORDER;
               state_d  = live_q[head_stock] ? S_ISSUE_CXL : S_ISSUE_ADD;
            end
         end
         S_ISSUE_CXL: begin
            state_d = S_WAIT_CXL;
            first_d = 1'b1;
         end
         S_WAIT_CXL: begin
            if (exit_wait) begin
               live_d[cmd_stock_q] = 1'b0;
               if (flushing_q) begin
                  state_d = S_FLUSH_SCAN;
               end else begin
                  ld      = 1'b1;
                  state_d = S_ISSUE_ADD;
               end
            end
         end
         S_ISSUE_ADD: begin
            state_d = S_WAIT_ADD;
            first_d = 1'b1;
         end
         S_WAIT_ADD: begin
            if (exit_wait) begin
               live_d[cmd_stock_q] = 1'b1;
               cnt_d               = cnt_q + 16'd1;
               state_d             = S_IDLE;
            end
         end
         S_FLUSH_SCAN: begin
            // Index stays put across a cancel; the re-visit sees the bit cleared and moves on.
            if (live_q[idx_q]) begin
               ld       = 1'b1;
               ld_stock = idx_q;
               ld_price = '0;
               ld_req   = CANCEL_ORDER;
               state_d  = S_ISSUE_CXL;
            end else if (idx_q == STOCK_W'(NUM_STOCK_INDEX)) begin
               flush_pend_d = 1'b0;
               flushing_d   = 1'b0;
               state_d      = S_IDLE;
            end else begin
               idx_d = idx_q + STOCK_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_stock_d = cmd_stock_q;
      cmd_req_d   = cmd_req_q;
      cmd_price_d = cmd_price_q;
      oid_d       = oid_q;
      qty_d       = qty_q;
      if (ld) begin
         cmd_stock_d = ld_stock;
         cmd_req_d   = ld_req;
         cmd_price_d = ld_price;
         oid_d       = OID;
         qty_d       = QTY;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= S_IDLE;
         stock_q      <= '0;
         price_q      <= '0;
         idx_q        <= '0;
         flushing_q   <= 1'b0;
         flush_pend_q <= 1'b0;
         first_q      <= 1'b0;
         live_q       <= '0;
         cnt_q        <= '0;
         cmd_stock_q  <= '0;
         cmd_req_q    <= ADD_ORDER;
         cmd_price_q  <= '0;
         oid_q        <= '0;
         qty_q        <= '0;
      end else begin
         state_q      <= state_d;
         stock_q      <= stock_d;
         price_q      <= price_d;
         idx_q        <= idx_d;
         flushing_q   <= flushing_d;
         flush_pend_q <= flush_pend_d;
         first_q      <= first_d;
         live_q       <= live_d;
         cnt_q        <= cnt_d;
         cmd_stock_q  <= cmd_stock_d;
         cmd_req_q    <= cmd_req_d;
         cmd_price_q  <= cmd_price_d;
         oid_q        <= oid_d;
         qty_q        <= qty_d;
      end
   end

endmodule
